// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe
//   Pipelined logarithmic barrel shifter supporting SLL, SRL, SRA, ROL and ROR.
//   An input capture stage is followed by SHW right-shift levels, each
//   registered. Level k shifts by 2^k when bit k of the shift amount is set.
//   Left operations bit-reverse the operand on entry and the result on exit.
//   All stages advance together under a single global stall.
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous discard of all in-flight operations
//   in_valid_i   operation offered
//   in_ready_o   operation accepted when high together with in_valid_i
//   in_data_i    operand (WIDTH)
//   in_shamt_i   unsigned shift amount (SHW)
//   in_op_i      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//   in_tag_i     sideband tag, returned unchanged
//   out_valid_o  result present
//   out_ready_i  consumer accepts result
//   out_data_o   result (0 for illegal op)
//   out_tag_o    tag of the operation
//   out_err_o    operation had an illegal op code
module shift_unit_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [SHW-1:0]   in_shamt_i,
  input  logic [2:0]       in_op_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_err_o
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  logic             w_adv;
  logic             w_legal;
  logic             w_rev;
  logic             w_rot;
  logic             w_fill;
  logic [WIDTH-1:0] w_in_data;
  logic [WIDTH-1:0] w_lvl [SHW];
  logic [WIDTH-1:0] w_res;

  // Stage registers: index k feeds shifter level k.
  logic             r_v [SHW];
  logic [WIDTH-1:0] r_d [SHW];
  logic [TAG_W-1:0] r_t [SHW];
  logic             r_e [SHW];
  logic [SHW-1:0]   r_s [SHW];  // remaining shift bits, bit 0 used by this level
  logic             r_f [SHW];  // fill bit for non-rotating shifts
  logic             r_r [SHW];  // rotate
  logic             r_b [SHW];  // bit-reverse result at exit (left ops)

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_err;

  assign w_adv       = !r_out_valid || out_ready_i;
  assign in_ready_o  = w_adv && !flush_i;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_tag_o   = r_out_tag;
  assign out_err_o   = r_out_err;

  // Decode the op into shifter controls and prepare the entry operand.
  always_comb begin
    w_legal = 1'b1;
    w_rev   = 1'b0;
    w_rot   = 1'b0;
    w_fill  = 1'b0;
    case (in_op_i)
      OP_SLL: w_rev = 1'b1;
      OP_SRL: w_rev = 1'b0;
      OP_SRA: w_fill = in_data_i[WIDTH-1];
      OP_ROL: begin
        w_rev = 1'b1;
        w_rot = 1'b1;
      end
      OP_ROR: w_rot = 1'b1;
      default: w_legal = 1'b0;
    endcase
    // Illegal ops shift a zero operand with zero fill, giving a zero result.
    if (!w_legal) begin
      w_in_data = {WIDTH{1'b0}};
    end else if (w_rev) begin
      w_in_data = bit_rev(in_data_i);
    end else begin
      w_in_data = in_data_i;
    end
  end

  // Shifter levels: level k conditionally shifts right by 2^k.
  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int AMT = 32'd1 << k;
    logic [WIDTH-1:0] w_sh;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_fillv;
    assign w_sh     = r_d[k] >> AMT;
    assign w_wrap   = r_d[k] << (WIDTH - AMT);
    assign w_fillv  = r_f[k] ? ~({WIDTH{1'b1}} >> AMT) : {WIDTH{1'b0}};
    assign w_lvl[k] = !r_s[k][0] ? r_d[k] :
                      (r_r[k] ? (w_sh | w_wrap) : (w_sh | w_fillv));
  end

  assign w_res = r_b[SHW-1] ? bit_rev(w_lvl[SHW-1]) : w_lvl[SHW-1];

  // Valid bits of every stage: cleared by reset or flush, shifted on advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SHW; i++) r_v[i] <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < SHW; i++) r_v[i] <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= in_valid_i;
      for (int i = 1; i < SHW; i++) r_v[i] <= r_v[i-1];
      r_out_valid <= r_v[SHW-1];
    end
  end

  // Internal datapath stages; contents are don't-care while the valid bit is low.
  always_ff @(posedge clk_i) begin
    if (w_adv) begin
      r_d[0] <= w_in_data;
      r_t[0] <= in_tag_i;
      r_e[0] <= !w_legal;
      r_s[0] <= in_shamt_i;
      r_f[0] <= w_fill;
      r_r[0] <= w_rot;
      r_b[0] <= w_rev;
      for (int i = 1; i < SHW; i++) begin
        r_d[i] <= w_lvl[i-1];
        r_t[i] <= r_t[i-1];
        r_e[i] <= r_e[i-1];
        r_s[i] <= r_s[i-1] >> 1'b1;
        r_f[i] <= r_f[i-1];
        r_r[i] <= r_r[i-1];
        r_b[i] <= r_b[i-1];
      end
    end
  end

  // Output registers, held while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_data <= {WIDTH{1'b0}};
      r_out_tag  <= {TAG_W{1'b0}};
      r_out_err  <= 1'b0;
    end else if (w_adv) begin
      r_out_data <= w_res;
      r_out_tag  <= r_t[SHW-1];
      r_out_err  <= r_e[SHW-1];
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Testbench for shift_unit_pipe (WIDTH=32, TAG_W=4): directed cases followed
// by randomized traffic with random back-pressure and occasional flushes,
// checked against a queue-based reference model.
module tb_shift_unit_pipe;

  localparam int SHW = 5;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  int   n_tests;
  int   n_fail;
  int   n_deliv;
  int   n_acc;
  logic last_acc;
  logic last_in_ready;
  logic held_v;
  logic [31:0] held_d;
  logic [3:0]  held_t;
  logic        held_e;
  exp_t exp_q[$];

  shift_unit_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_shamt_i(in_shamt), .in_op_i(in_op), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_tag_o(out_tag), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal 32-bit shifts, rotations built from a doubled operand.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] d,
                                 input logic [4:0] sh, output logic [31:0] r,
                                 output logic e);
    logic [63:0] dd;
    dd = {d, d};
    e = 1'b0;
    case (op)
      3'd0: r = d << sh;
      3'd1: r = d >> sh;
      3'd2: r = $signed(d) >>> sh;
      3'd3: begin dd = dd << sh; r = dd[63:32]; end
      3'd4: begin dd = dd >> sh; r = dd[31:0]; end
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endfunction

  // One clock cycle: drive, check mid-cycle, update model, advance past the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] sh,
                      input logic [2:0] op, input logic [3:0] tg,
                      input logic rdy, input logic fl);
    exp_t        e;
    logic [31:0] rd;
    logic        re;
    in_valid = v; in_data = d; in_shamt = sh; in_op = op; in_tag = tg;
    out_ready = rdy; flush = fl;
    #3;
    chk("in_ready", in_ready, (!out_valid || rdy) && !fl);
    last_in_ready = in_ready;
    if (held_v) begin
      chk("hold_data", out_data, held_d);
      chk("hold_tag", out_tag, held_t);
      chk("hold_err", out_err, held_e);
    end
    if (out_valid && rdy) begin
      chk("q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("model_data", out_data, e.d);
        chk("model_tag", out_tag, e.t);
        chk("model_err", out_err, e.e);
      end
      n_deliv++;
    end
    last_acc = v && in_ready;
    if (last_acc) begin
      ref_op(op, d, sh, rd, re);
      exp_q.push_back('{d: rd, t: tg, e: re});
      n_acc++;
    end
    held_v = out_valid && !rdy && !fl;
    held_d = out_data; held_t = out_tag; held_e = out_err;
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 5'd0, 3'd0, 4'd0, 1'b1, 1'b0);
  endtask

  // Single op into an empty pipe: checks latency and a fixed expected result.
  task automatic run1(input string nm, input logic [31:0] d, input logic [4:0] sh,
                      input logic [2:0] op, input logic [3:0] tg,
                      input logic [31:0] exp_d, input logic exp_e);
    step(1'b1, d, sh, op, tg, 1'b1, 1'b0);
    chk({nm, "_acc"}, last_acc, 1);
    for (int c = 0; c < SHW; c++) begin
      chk({nm, "_early"}, out_valid, 0);
      idle();
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, exp_d);
    chk({nm, "_tag"}, out_tag, tg);
    chk({nm, "_err"}, out_err, exp_e);
    idle();
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) idle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int sent;
    int base;
    int n_stall_low;
    int cyc;
    logic rdy;
    n_tests = 0; n_fail = 0; n_deliv = 0; n_acc = 0;
    held_v = 1'b0; held_d = 32'd0; held_t = 4'd0; held_e = 1'b0;
    last_acc = 1'b0; last_in_ready = 1'b0;
    clk = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'd0; in_shamt = 5'd0; in_op = 3'd0; in_tag = 4'd0;

    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_err", out_err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run1("sra31", 32'h80000000, 5'd31, 3'd2, 4'h1, 32'hFFFFFFFF, 1'b0);
    run1("srl31", 32'h80000000, 5'd31, 3'd1, 4'h2, 32'h00000001, 1'b0);
    run1("sll31", 32'h00000001, 5'd31, 3'd0, 4'h3, 32'h80000000, 1'b0);
    run1("rol1",  32'h80000001, 5'd1,  3'd3, 4'h4, 32'h00000003, 1'b0);
    run1("ror8",  32'h12345678, 5'd8,  3'd4, 4'h5, 32'h78123456, 1'b0);
    run1("illeg", 32'hFFFFFFFF, 5'd7,  3'b101, 4'h6, 32'h00000000, 1'b1);
    run1("legal", 32'h000000F0, 5'd4,  3'd1, 4'h7, 32'h0000000F, 1'b0);
    run1("rol0",  32'hDEADBEEF, 5'd0,  3'd3, 4'h8, 32'hDEADBEEF, 1'b0);
    run1("sra0",  32'h9ABCDEF0, 5'd0,  3'd2, 4'h9, 32'h9ABCDEF0, 1'b0);
    run1("sll0",  32'h13572468, 5'd0,  3'd0, 4'hA, 32'h13572468, 1'b0);

    // Eight back-to-back ops with three stalled cycles mid-stream.
    sent = 0; n_stall_low = 0; base = n_deliv;
    for (int c = 0; c < 60 && (sent < 8 || exp_q.size() > 0); c++) begin
      rdy = !(c >= 6 && c <= 8);
      step(sent < 8, $urandom, 5'(sent * 3), 3'(sent % 5), 4'(sent), rdy, 1'b0);
      if (!rdy && !last_in_ready) n_stall_low++;
      if (last_acc) sent++;
    end
    chk("stall_in_ready_low", n_stall_low, 3);
    chk("stall_delivered", n_deliv - base, 8);

    // Flush with three ops in flight.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 5'(i + 1), 3'd1, 4'(i), 1'b1, 1'b0);
    step(1'b0, 32'd0, 5'd0, 3'd0, 4'd0, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 0);
    base = n_deliv;
    for (int i = 0; i < 8; i++) idle();
    chk("flush_none", n_deliv - base, 0);
    run1("postfl", 32'h0000FF00, 5'd8, 3'd4, 4'hC, 32'h000000FF, 1'b0);

    // Asynchronous reset between edges with ops in flight.
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 5'(i), 3'd0, 4'(i), 1'b1, 1'b0);
    chk("prerst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_tag", out_tag, 0);
    chk("arst_err", out_err, 0);
    exp_q.delete();
    held_v = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run1("postrst", 32'h00000081, 5'd1, 3'd0, 4'hD, 32'h00000102, 1'b0);

    // Randomized legal traffic against the reference model.
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      step($urandom_range(0, 9) < 8, $urandom, 5'($urandom_range(0, 31)),
           3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 249) == 0);
      cyc++;
    end
    chk("rand_ops", n_acc >= 10000, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_pipe.md
SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL derive localparam SHW = log2(WIDTH), default 5; shift-amount width and pipeline depth.
REQ-004 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  synchronous discard of all in-flight operations.
REQ-007 SHALL have port in_valid_i  input  1  operation offered.
REQ-008 SHALL have port in_ready_o  output  1  operation accepted when high with in_valid_i.
REQ-009 SHALL have port in_data_i  input  WIDTH  operand.
REQ-010 SHALL have port in_shamt_i  input  SHW  shift amount, unsigned.
REQ-011 SHALL have port in_op_i  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal.
REQ-012 SHALL have port in_tag_i  input  TAG_W  sideband, returned unchanged.
REQ-013 SHALL have port out_valid_o  output  1  result present.
REQ-014 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-015 SHALL have port out_data_o  output  WIDTH  result.
REQ-016 SHALL have port out_tag_o  output  TAG_W  tag of the operation.
REQ-017 SHALL have port out_err_o  output  1  operation had illegal op code.

Function
REQ-018 SHALL implement a logarithmic shifter of SHW levels; level k shifts by 2^k when shamt bit k set, LSB level first; one register stage after each level.
REQ-019 SHALL compute left ops by bit-reversing the operand before level 0 and the result after the last level; right-shift levels only.
REQ-020 SHALL fill vacated bits with 0 for SLL/SRL, operand MSB for SRA, and wrapped-out bits for ROL/ROR.
REQ-021 SHALL produce results equal to ideal SLL/SRL/SRA/ROL/ROR of WIDTH bits by shamt mod WIDTH; shamt 0 returns operand unchanged for all legal ops.
REQ-022 SHALL, for illegal op, produce out_data_o = 0 and out_err_o = 1; out_err_o = 0 for legal ops.
REQ-023 SHALL carry valid, tag, op class and error bit alongside data in every stage.
REQ-024 SHALL have fixed latency SHW cycles: op accepted at edge N appears on out_valid_o after edge N+SHW when no stall.
REQ-025 SHALL define advance = !out_valid_o || out_ready_i; all stages shift together only when advance is high (global stall).
REQ-026 SHALL drive in_ready_o = advance, combinationally; bubbles (in_valid_i low on accept slot) propagate as invalid stages.
REQ-027 SHALL hold out_data_o, out_tag_o, out_err_o stable while out_valid_o high and out_ready_i low.
REQ-028 SHALL sustain one accept and one result per cycle when out_ready_i stays high.
REQ-029 SHALL preserve operation order; no operation lost or duplicated under any stall pattern.
REQ-030 SHALL, on flush_i high at an edge, clear every stage valid bit; in_ready_o forced low during flush_i so no op is accepted that cycle.
REQ-031 SHALL, when flush_i and out_ready_i are both high with out_valid_o high, count the output as consumed and then cleared (no duplicate next cycle).

Reset
REQ-032 SHALL, on rst_i assertion, immediately clear all stage valid bits, out_valid_o = 0, out_err_o = 0, out_data_o = 0, out_tag_o = 0, regardless of clock.
REQ-033 SHALL discard operations in flight when reset asserts mid-operation; first accept allowed on first rising edge after rst_i deasserts.
REQ-034 SHALL not reset datapath registers other than those driving outputs.

Verification (WIDTH=32)
REQ-035 SHALL cover SRA 0x80000000 shamt 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; out_valid_o exactly 5 cycles after accept.
REQ-036 SHALL cover SLL 0x00000001 shamt 31 -> 0x80000000; ROL 0x80000001 shamt 1 -> 0x00000003; ROR 0x12345678 shamt 8 -> 0x78123456; tags echoed.
REQ-037 SHALL cover 8 back-to-back ops with out_ready_i low for 3 cycles mid-stream -> in_ready_o low those cycles, all 8 results delivered in order, output stable while stalled.
REQ-038 SHALL cover op 3'b101 operand 0xFFFFFFFF -> out_data_o 0x00000000, out_err_o 1, following legal op out_err_o 0.
REQ-039 SHALL cover flush_i one cycle with 3 ops in flight -> out_valid_o 0 next cycle, none of the 3 delivered, next accepted op delivered normally.
REQ-040 SHALL cover rst_i asserted between edges with ops in flight -> out_valid_o 0 before next edge; random legal ops vs reference model after release, 10k ops, zero mismatches.
